// File: rtl/mem_bus_defs.sv
// Shared data-bus definitions: memory width codes, responder state encoding
// and helpers for byte-lane enables and alignment checks.
package mem_bus_defs;

  localparam logic [1:0] MEM_WIDTH_WORD = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } resp_state_t;

  // Width code 2'b11 falls through to the word case everywhere.
  function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      MEM_WIDTH_HALF: byte_enables = lo[1] ? 4'b1100 : 4'b0011;
      MEM_WIDTH_BYTE: byte_enables = 4'b0001 << lo;
      default:        byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      MEM_WIDTH_HALF: is_misaligned = lo[0];
      MEM_WIDTH_BYTE: is_misaligned = 1'b0;
      default:        is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM with per-byte write enables and a registered,
// read-enabled output that holds its value between reads.
module data_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder: accepts core load/store strobes, steers byte lanes into
// the data RAM, extends load results and reports misaligned accesses.
module data_bus_responder
  import mem_bus_defs::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [1:0]  bus_mem_width,
  input  logic        bus_load_signed,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        bus_busy,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int WORD_AW = ADDR_WIDTH - 2;

  resp_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [1:0]  lo_reg, width_reg;
  logic        sign_reg, misal_reg;
  logic        fault_reg;
  logic [31:0] fault_addr_reg;

  logic        accept, misaligned, rd_go, wr_go, fault_go;
  logic [31:0] wdata_rep, ram_rdata, ext_data;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Requests arriving during wait states are dropped without side effects.
  assign accept     = (state_reg != WAIT);
  assign misaligned = is_misaligned(bus_mem_width, bus_addr[1:0]);
  assign rd_go      = accept && bus_read && !bus_write;
  assign wr_go      = accept && bus_write && !misaligned;
  assign fault_go   = accept && ((bus_read && bus_write) ||
                                 ((bus_read || bus_write) && misaligned));

  always_comb begin
    case (bus_mem_width)
      MEM_WIDTH_HALF: wdata_rep = {2{bus_wdata[15:0]}};
      MEM_WIDTH_BYTE: wdata_rep = {4{bus_wdata[7:0]}};
      default:        wdata_rep = bus_wdata;
    endcase
  end

  data_ram #(.AW(WORD_AW)) u_ram (
    .clk   (clk),
    .addr  (bus_addr[ADDR_WIDTH-1:2]),
    .we    (wr_go),
    .be    (byte_enables(bus_mem_width, bus_addr[1:0])),
    .wdata (wdata_rep),
    .re    (rd_go),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (!rd_go) begin
          state_next = IDLE;
        end else if (WAIT_STATES == 0) begin
          state_next = RESP;
        end else begin
          state_next = WAIT;
          cnt_next   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = RESP;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      lo_reg         <= 2'b00;
      width_reg      <= MEM_WIDTH_WORD;
      sign_reg       <= 1'b0;
      misal_reg      <= 1'b0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_go;
      if (fault_go) fault_addr_reg <= bus_addr;
      if (rd_go) begin
        lo_reg    <= bus_addr[1:0];
        width_reg <= bus_mem_width;
        sign_reg  <= bus_load_signed;
        misal_reg <= misaligned;
      end
    end
  end

  // Lane steering works off the request qualifiers latched at accept time.
  always_comb begin
    half_sel = lo_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    byte_sel = ram_rdata[{lo_reg, 3'b000} +: 8];
    case (width_reg)
      MEM_WIDTH_HALF: ext_data = {{16{sign_reg & half_sel[15]}}, half_sel};
      MEM_WIDTH_BYTE: ext_data = {{24{sign_reg & byte_sel[7]}}, byte_sel};
      default:        ext_data = ram_rdata;
    endcase
  end

  assign bus_rvalid = (state_reg == RESP);
  assign bus_busy   = (state_reg == WAIT);
  assign bus_rdata  = (bus_rvalid && !misal_reg) ? ext_data : 32'd0;
  assign fault      = fault_reg;
  assign fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: table-driven vectors with a due-cycle
// scoreboard on a zero-wait instance, hand sequences on a 3-wait instance.
module tb_data_bus_responder;

  localparam logic [1:0] WD = 2'b00;
  localparam logic [1:0] HF = 2'b01;
  localparam logic [1:0] BY = 2'b10;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // zero-wait instance
  logic        rst0_n = 1'b0, d0_read = 1'b0, d0_write = 1'b0, d0_sgn = 1'b0;
  logic [31:0] d0_addr = '0, d0_wdata = '0;
  logic [1:0]  d0_width = 2'b00;
  logic [31:0] d0_rdata, d0_fault_addr;
  logic        d0_rvalid, d0_busy, d0_fault;

  // three-wait instance
  logic        rst3_n = 1'b0, d3_read = 1'b0, d3_write = 1'b0, d3_sgn = 1'b0;
  logic [31:0] d3_addr = '0, d3_wdata = '0;
  logic [1:0]  d3_width = 2'b00;
  logic [31:0] d3_rdata, d3_fault_addr;
  logic        d3_rvalid, d3_busy, d3_fault;

  data_bus_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(rst0_n), .bus_read(d0_read), .bus_write(d0_write),
    .bus_addr(d0_addr), .bus_wdata(d0_wdata), .bus_mem_width(d0_width),
    .bus_load_signed(d0_sgn), .bus_rdata(d0_rdata), .bus_rvalid(d0_rvalid),
    .bus_busy(d0_busy), .fault(d0_fault), .fault_addr(d0_fault_addr)
  );

  data_bus_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset_n(rst3_n), .bus_read(d3_read), .bus_write(d3_write),
    .bus_addr(d3_addr), .bus_wdata(d3_wdata), .bus_mem_width(d3_width),
    .bus_load_signed(d3_sgn), .bus_rdata(d3_rdata), .bus_rvalid(d3_rvalid),
    .bus_busy(d3_busy), .fault(d3_fault), .fault_addr(d3_fault_addr)
  );

  exp_t rq[$];
  exp_t fq[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] width,
                              input logic sgn, input logic [31:0] exp_data,
                              input logic exp_fault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.width = width;
    v.sgn = sgn; v.exp_data = exp_data; v.exp_fault = exp_fault;
    return v;
  endfunction

  // Scoreboard for dut0: every cycle with an expected or an actual event is a check.
  always @(negedge clk) begin
    logic want;
    want = (rq.size() > 0) && (rq[0].due == cyc);
    if (want || d0_rvalid) begin
      checks++;
      if (!want) begin
        errors++;
        $display("FAIL rvalid_spurious cyc=%0d: got rvalid=1 rdata=%08h required rvalid=0", cyc, d0_rdata);
      end else if (!d0_rvalid) begin
        errors++;
        $display("FAIL rvalid_missing cyc=%0d: got rvalid=0 required rdata=%08h", cyc, rq[0].data);
      end else if (d0_rdata !== rq[0].data) begin
        errors++;
        $display("FAIL rdata cyc=%0d: got %08h required %08h", cyc, d0_rdata, rq[0].data);
      end
      if (want) void'(rq.pop_front());
    end
    want = (fq.size() > 0) && (fq[0].due == cyc);
    if (want || d0_fault) begin
      checks++;
      if (!want) begin
        errors++;
        $display("FAIL fault_spurious cyc=%0d: got fault=1 required fault=0", cyc);
      end else if (!d0_fault || d0_fault_addr !== fq[0].data) begin
        errors++;
        $display("FAIL fault cyc=%0d: got fault=%b addr=%08h required fault=1 addr=%08h",
                 cyc, d0_fault, d0_fault_addr, fq[0].data);
      end
      if (want) void'(fq.pop_front());
    end
  end

  initial begin
    vecs.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, WD, 0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 32'h10,   32'h0,        WD, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 32'h13,   32'h00000080, BY, 0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 32'h13,   32'h0,        BY, 1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(1, 0, 32'h13,   32'h0,        BY, 0, 32'h00000080, 0));
    vecs.push_back(mk(1, 0, 32'h10,   32'h0,        WD, 0, 32'h80ADBEEF, 0));
    vecs.push_back(mk(0, 1, 32'h20,   32'hAAAA9678, WD, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 32'h22,   32'hFFFF1234, HF, 0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 32'h22,   32'h0,        HF, 1, 32'h00001234, 0));
    vecs.push_back(mk(1, 0, 32'h20,   32'h0,        HF, 1, 32'hFFFF9678, 0));
    vecs.push_back(mk(1, 0, 32'h20,   32'h0,        HF, 0, 32'h00009678, 0));
    vecs.push_back(mk(1, 0, 32'h21,   32'h0,        HF, 0, 32'h0,        1));
    vecs.push_back(mk(0, 1, 32'h30,   32'hCAFEF00D, WD, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 32'h32,   32'h11111111, WD, 0, 32'h0,        1));
    vecs.push_back(mk(1, 0, 32'h30,   32'h0,        WD, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 1, 32'h31,   32'h7755AA5A, BY, 0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 32'h30,   32'h0,        WD, 0, 32'hCAFE5A0D, 0));
    vecs.push_back(mk(1, 0, 32'h10,   32'h0,        2'b11, 0, 32'h80ADBEEF, 0));
    vecs.push_back(mk(1, 0, 32'h1010, 32'h0,        WD, 0, 32'h80ADBEEF, 0));
    vecs.push_back(mk(1, 1, 32'h40,   32'h01020304, WD, 0, 32'h0,        1));
    vecs.push_back(mk(1, 0, 32'h40,   32'h0,        WD, 0, 32'h01020304, 0));
    vecs.push_back(mk(1, 0, 32'h12,   32'h0,        WD, 0, 32'h0,        1));
    vecs.push_back(mk(1, 0, 32'h12,   32'h0,        BY, 1, 32'hFFFFFFAD, 0));
    vecs.push_back(mk(1, 0, 32'h12,   32'h0,        HF, 0, 32'h000080AD, 0));

    // reset state of both instances
    repeat (2) @(negedge clk);
    chk("rst0_rdata", d0_rdata, 32'h0);
    chk("rst0_rvalid", {31'd0, d0_rvalid}, 32'h0);
    chk("rst0_busy", {31'd0, d0_busy}, 32'h0);
    chk("rst0_fault", {31'd0, d0_fault}, 32'h0);
    chk("rst0_fault_addr", d0_fault_addr, 32'h0);
    chk("rst3_busy", {31'd0, d3_busy}, 32'h0);
    rst0_n = 1'b1;
    rst3_n = 1'b1;

    // table vectors on the zero-wait instance, back to back
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      d0_read  = vecs[i].rd;
      d0_write = vecs[i].wr;
      d0_addr  = vecs[i].addr;
      d0_wdata = vecs[i].wdata;
      d0_width = vecs[i].width;
      d0_sgn   = vecs[i].sgn;
      if (vecs[i].rd && !vecs[i].wr) rq.push_back('{cyc + 1, vecs[i].exp_data});
      if (vecs[i].exp_fault) fq.push_back('{cyc + 1, vecs[i].addr});
      $display("vec %0d: rd=%b wr=%b addr=%08h wdata=%08h width=%b sgn=%b exp=%08h exp_fault=%b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].width,
               vecs[i].sgn, vecs[i].exp_data, vecs[i].exp_fault);
    end
    @(posedge clk); #1;
    d0_read = 1'b0;
    d0_write = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard_rq_drained", rq.size(), 32'd0);
    chk("scoreboard_fq_drained", fq.size(), 32'd0);
    chk("busy0_never", {31'd0, d0_busy}, 32'h0);

    // three-wait instance: misaligned store makes fault_addr sticky
    @(posedge clk); #1;
    d3_write = 1'b1; d3_addr = 32'h33; d3_wdata = 32'h99999999; d3_width = WD;
    $display("ws3: misaligned word store @33");
    @(posedge clk); #1;
    d3_addr = 32'h10; d3_wdata = 32'h13572468;
    $display("ws3: word store 13572468 @10");
    @(negedge clk);
    chk("ws3_fault_pulse", {31'd0, d3_fault}, 32'h1);
    chk("ws3_fault_addr", d3_fault_addr, 32'h33);
    @(posedge clk); #1;
    d3_write = 1'b0; d3_read = 1'b1; d3_addr = 32'h10;
    $display("ws3: word load @10 with a second read during busy");
    @(posedge clk); #1;
    d3_addr = 32'h20;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("ws3_busy_k%0d", k), {31'd0, d3_busy}, {31'd0, (k <= 3)});
      chk($sformatf("ws3_rvalid_k%0d", k), {31'd0, d3_rvalid}, {31'd0, (k == 4)});
      if (k == 4) chk("ws3_rdata", d3_rdata, 32'h13572468);
      @(posedge clk); #1;
      d3_read = 1'b0;
    end

    // reset asserted in the middle of wait states
    d3_read = 1'b1; d3_addr = 32'h10;
    $display("ws3: word load @10 interrupted by reset");
    @(posedge clk); #1;
    d3_read = 1'b0;
    @(negedge clk);
    chk("ws3_busy_before_reset", {31'd0, d3_busy}, 32'h1);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    chk("ws3_rst_rdata", d3_rdata, 32'h0);
    chk("ws3_rst_rvalid", {31'd0, d3_rvalid}, 32'h0);
    chk("ws3_rst_busy", {31'd0, d3_busy}, 32'h0);
    chk("ws3_rst_fault", {31'd0, d3_fault}, 32'h0);
    chk("ws3_rst_fault_addr", d3_fault_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("ws3_no_resp_after_reset_%0d", k), {31'd0, d3_rvalid}, 32'h0);
    end
    @(posedge clk); #1;
    d3_read = 1'b1; d3_addr = 32'h10;
    $display("ws3: word load @10 after reset");
    @(posedge clk); #1;
    d3_read = 1'b0;
    repeat (4) @(negedge clk);
    chk("ws3_reread_rvalid", {31'd0, d3_rvalid}, 32'h1);
    chk("ws3_reread_rdata", d3_rdata, 32'h13572468);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

- Bus-side responder for the CPU data bus; services the core's `bus_read`/`bus_write` strobes together with their memory-width and load-sign qualifiers.
- Contains byte-addressable synchronous data RAM; performs byte-lane write masking, load lane extraction and sign/zero extension.
- Returns read data after a fixed, parameterised latency and flags misaligned accesses.
- Sits between the execute/memory stage and data memory; its one-cycle base read latency is what the core's load stall covers.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, byte-address bits decoded; RAM depth 2^(ADDR_WIDTH-2) words; higher address bits ignored (aliasing).
- `WAIT_STATES`, 0, extra read cycles beyond base latency (0..15).

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `bus_read` input 1: read request strobe.
- `bus_write` input 1: write request strobe.
- `bus_addr` input 32: byte address.
- `bus_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `bus_mem_width` input 2: 00 word, 01 half, 10 byte, 11 treated as word.
- `bus_load_signed` input 1: sign-extend half/byte loads.
- `bus_rdata` output 32: extended load result, valid only with `bus_rvalid`.
- `bus_rvalid` output 1: one-cycle read-response pulse.
- `bus_busy` output 1: responder in wait states; requests ignored.
- `fault` output 1: one-cycle pulse on misaligned access.
- `fault_addr` output 32: address of most recent faulting access; sticky.

## Operation
States:
- IDLE
- WAIT: wait-state countdown.
- RESP: drives `bus_rvalid`.

Request acceptance:
- Accepted in IDLE or RESP when `bus_busy`=0.
- Requests while in WAIT are dropped, no side effects.

Read:
- On accept, latch `addr[1:0]`, width and sign; issue RAM read.
- If `WAIT_STATES`=0, go to RESP.
- Otherwise load counter with `WAIT_STATES` and go to WAIT.
- WAIT decrements the counter; enters RESP when it reaches 1.
- RESP returns to IDLE unless a new read is accepted in that cycle.

Load extraction:
- Word: the full RAM word.
- Half: `addr[1]` selects [31:16] else [15:0].
- Byte: `addr[1:0]` selects the lane.
- Upper bits are sign-extended if `bus_load_signed`, otherwise zero.

Write:
- Single cycle; committed at the accepting edge; no state change and no `bus_busy`.
- Byte enables: word 1111; half `addr[1]`?1100:0011; byte 0001<<`addr[1:0]`.
- Data is replicated into the enabled lanes.

Misalignment (half with `addr[0]`=1, or word with `addr[1:0]`≠0):
- No RAM write.
- A misaligned read still completes on schedule with `bus_rdata`=0.
- `fault` pulses the cycle after accept; `fault_addr` loads `bus_addr`.

Simultaneous `bus_read` and `bus_write`:
- The write executes; the read is ignored (no `bus_rvalid`).
- Counts as a fault with `fault_addr` = address.

Reset (asserted at any time, including mid-read):
- State goes to IDLE and the counter clears.
- `bus_rdata`=0, `bus_rvalid`=0, `bus_busy`=0, `fault`=0, `fault_addr`=0.
- The in-flight read is lost, with no response after reset release.
- RAM contents are not reset.

## Timing
- Read accepted at edge N: `bus_rvalid` high during cycle N+1+`WAIT_STATES`, for exactly one cycle.
- `bus_busy` high during cycles N+1 .. N+`WAIT_STATES`; never high when `WAIT_STATES`=0.
- Back-to-back reads: a read accepted in a RESP cycle gives the next `bus_rvalid` at the same relative latency.
  - With 0 wait states, `bus_rvalid` can be continuously high.
- Write at edge N followed by a read of the same address accepted at N+1 returns the new data (write-first by ordering).
- `bus_rdata`, `bus_rvalid`, `bus_busy`, `fault` and `fault_addr` are all registered outputs.
- No combinational path from inputs to outputs.

## Structure
- Shared package `mem_bus_defs` holds:
  - width codes `MEM_WIDTH_WORD`=2'b00, `MEM_WIDTH_HALF`=2'b01, `MEM_WIDTH_BYTE`=2'b10;
  - the state encoding for IDLE/WAIT/RESP.
- These codes are also used by the control unit's width output.
- One sub-module, `data_ram`:
  - 32-bit word array with 4-bit byte enables;
  - synchronous read, registered output;
  - no reset.
- Lane steering, extension, FSM and fault logic stay in `data_bus_responder`.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 (`WAIT_STATES`=0) -> `bus_rvalid` one cycle after accept, `bus_rdata`=0xDEADBEEF.
- Byte store 0x80 @0x13, then signed byte load @0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
- Half store 0x1234 @0x22, then signed half load @0x22 -> 0x00001234; half load @0x20 -> previous low half unchanged.
- Half load @0x21 -> `fault` pulse, `fault_addr`=0x21, `bus_rdata`=0 with `bus_rvalid`; misaligned word store @0x32 -> RAM unchanged, `fault_addr`=0x32.
- `WAIT_STATES`=3, read @0x10 -> `bus_busy` for 3 cycles, a second read during busy is ignored, `bus_rvalid` at N+4.
- `WAIT_STATES`=3, assert `reset_n`=0 during WAIT -> all outputs 0 immediately, no `bus_rvalid` after release, RAM data intact on re-read.
